// File: rtl/render_sched.sv
// Raster pixel-job scheduler: round-robin dispatch to NUM_CORES datapaths, in-order merge of their results.
// Latency: job offer one cycle after start; result path to out_* is combinational. Backpressure: out_ready stalls the current core.
// Optional RENDER_SCHED_PERF_EN adds the perf_cycles frame cycle counter; otherwise perf_cycles is tied to 0.
module render_sched #(
   parameter int NUM_CORES = 4,
   parameter int COORD_W   = 16
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     start,
   input  logic [COORD_W-1:0]       image_width,
   input  logic [COORD_W-1:0]       image_height,
   output logic                     busy,
   output logic                     done,
   output logic [NUM_CORES-1:0]     job_valid,
   input  logic [NUM_CORES-1:0]     job_ready,
   output logic [COORD_W-1:0]       job_x,
   output logic [COORD_W-1:0]       job_y,
   input  logic [NUM_CORES-1:0]     frag_valid,
   input  logic [32*NUM_CORES-1:0]  frag_data,
   output logic [NUM_CORES-1:0]     frag_ready,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_data,
   output logic                     out_last,
   output logic [31:0]              perf_cycles
);

   localparam int PW = $clog2(NUM_CORES);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t               state;
   logic [COORD_W-1:0]   width_q, height_q, x_q, y_q;
   logic [31:0]          total_q, count_q;
   logic [NUM_CORES-1:0] outstanding;
   logic [PW-1:0]        dptr, cptr;

   logic                 active, disp_ok, disp_fire, coll_ok, coll_fire;
   logic [NUM_CORES-1:0] disp_mask, coll_mask;

   function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
      return (p == PW'(NUM_CORES - 1)) ? '0 : p + PW'(1);
   endfunction

   assign active    = (state != IDLE);
   assign disp_ok   = (state == RUN) && !outstanding[dptr];
   assign disp_fire = disp_ok && job_ready[dptr];
   assign coll_ok   = active && outstanding[cptr];
   assign out_valid = coll_ok && frag_valid[cptr];
   assign coll_fire = out_valid && out_ready;
   assign out_last  = out_valid && (count_q + 32'd1 == total_q);
   assign job_x     = x_q;
   assign job_y     = y_q;

   assign disp_mask = disp_fire ? (NUM_CORES'(1) << dptr) : '0;
   assign coll_mask = coll_fire ? (NUM_CORES'(1) << cptr) : '0;

   always_comb begin
      job_valid  = '0;
      frag_ready = '0;
      out_data   = '0;
      for (int k = 0; k < NUM_CORES; k++) begin
         if (PW'(k) == dptr)
            job_valid[k] = disp_ok;
         if (PW'(k) == cptr) begin
            frag_ready[k] = coll_ok && out_ready;
            out_data      = frag_data[32*k +: 32];
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         width_q     <= '0;
         height_q    <= '0;
         x_q         <= '0;
         y_q         <= '0;
         total_q     <= '0;
         count_q     <= '0;
         outstanding <= '0;
         dptr        <= '0;
         cptr        <= '0;
      end else begin
         done <= 1'b0;

         if (state == IDLE && start) begin
            // Empty frames complete immediately without ever going busy.
            if (image_width == '0 || image_height == '0) begin
               done <= 1'b1;
            end else begin
               width_q  <= image_width;
               height_q <= image_height;
               total_q  <= 32'(image_width) * 32'(image_height);
               x_q      <= '0;
               y_q      <= '0;
               dptr     <= '0;
               cptr     <= '0;
               count_q  <= '0;
               busy     <= 1'b1;
               state    <= RUN;
            end
         end

         if (disp_fire) begin
            dptr <= inc_ptr(dptr);
            if (x_q == width_q - COORD_W'(1)) begin
               x_q <= '0;
               if (y_q == height_q - COORD_W'(1)) begin
                  y_q   <= '0;
                  state <= DRAIN;
               end else begin
                  y_q <= y_q + COORD_W'(1);
               end
            end else begin
               x_q <= x_q + COORD_W'(1);
            end
         end

         // The final fragment can only retire in DRAIN, so this never races the DRAIN transition above.
         if (coll_fire) begin
            cptr    <= inc_ptr(cptr);
            count_q <= count_q + 32'd1;
            if (out_last) begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
         end

         outstanding <= (outstanding | disp_mask) & ~coll_mask;
      end
   end

`ifdef RENDER_SCHED_PERF_EN
   logic [31:0] perf_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         perf_q <= '0;
      else if (state == IDLE && start)
         perf_q <= '0;
      else if (busy)
         perf_q <= perf_q + 32'd1;
   end

   assign perf_cycles = perf_q;
`else
   assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_render_sched.sv
// Directed bench for render_sched: behavioural cores with per-core reply delay, raster-order scoreboard.
module tb_render_sched;

   localparam int NC = 4;

   logic           clk = 1'b0;
   logic           resetn, start;
   logic [15:0]    image_width, image_height;
   logic           busy, done;
   logic [NC-1:0]  job_valid, job_ready;
   logic [15:0]    job_x, job_y;
   logic [NC-1:0]  frag_valid, frag_ready;
   logic [32*NC-1:0] frag_data;
   logic           out_valid, out_ready, out_last;
   logic [31:0]    out_data, perf_cycles;

   render_sched #(.NUM_CORES(NC), .COORD_W(16)) dut (
      .clk(clk), .resetn(resetn), .start(start),
      .image_width(image_width), .image_height(image_height),
      .busy(busy), .done(done),
      .job_valid(job_valid), .job_ready(job_ready), .job_x(job_x), .job_y(job_y),
      .frag_valid(frag_valid), .frag_data(frag_data), .frag_ready(frag_ready),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .perf_cycles(perf_cycles)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [NC-1:0] pend;
   int            cnt  [NC];
   logic [31:0]   cdat [NC];
   int            dly  [NC];

   int fw, fh, ntot, nout, ndisp, stepno, done_step, last_step, busy_cyc, stall2, stab, hold_at, hold_cnt;
   bit held, frame_done;

   logic [NC-1:0] s_jv, s_fr;
   logic [15:0]   s_jx, s_jy;
   logic          s_ov, s_ol, s_busy, s_done, s_ordy;
   logic [31:0]   s_od, s_perf;
   logic          p_ov, p_ordy, p_ol;
   logic [31:0]   p_od;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] raster(input int n);
      if (fw == 0) return 32'd0;
      return {16'(n / fw), 16'(n % fw)};
   endfunction

   function automatic logic [31:0] perf_exp();
`ifdef RENDER_SCHED_PERF_EN
      return 32'(busy_cyc);
`else
      return 32'd0;
`endif
   endfunction

   task automatic drive_frags();
      for (int k = 0; k < NC; k++) begin
         frag_valid[k]          = pend[k] && (cnt[k] == 0);
         frag_data[32*k +: 32]  = cdat[k];
      end
   endtask

   task automatic clear_cores();
      pend = '0;
      for (int k = 0; k < NC; k++) begin
         cnt[k]  = 0;
         cdat[k] = 32'd0;
      end
      drive_frags();
   endtask

   // One clock: sample and check at negedge, then advance the core models just after posedge.
   task automatic step();
      int c;
      @(negedge clk);
      s_jv = job_valid; s_fr = frag_ready; s_jx = job_x; s_jy = job_y;
      s_ov = out_valid; s_ol = out_last; s_od = out_data; s_ordy = out_ready;
      s_busy = busy; s_done = done; s_perf = perf_cycles;
      stepno++;
      if (s_busy) busy_cyc++;
      if (s_done && !frame_done) begin
         frame_done = 1'b1;
         done_step  = stepno;
      end
      if (s_jv != '0) begin
         chk("job_core", 32'(s_jv), 32'(1) << (ndisp % NC));
         chk("job_to_busy_core", 32'(s_jv & pend), 32'd0);
         chk("job_xy", {s_jy, s_jx}, raster(ndisp));
      end
      if (ndisp >= ntot) chk("job_after_end", 32'(s_jv), 32'd0);
      c = nout % NC;
      chk("out_valid", 32'(s_ov), 32'(pend[c] & frag_valid[c]));
      chk("frag_ready", 32'(s_fr), (s_ordy && pend[c]) ? (32'(1) << c) : 32'd0);
      if (s_ov) begin
         chk("out_data", s_od, raster(nout));
         chk("out_last", 32'(s_ol), 32'(nout == ntot - 1));
      end
      if (p_ov && !p_ordy) begin
         chk("hold_valid", 32'(s_ov), 32'd1);
         chk("hold_data", s_od, p_od);
         chk("hold_last", 32'(s_ol), 32'(p_ol));
         stab++;
      end
      if (frag_valid[2] && !s_fr[2]) stall2++;
      p_ov = s_ov; p_ordy = s_ordy; p_od = s_od; p_ol = s_ol;

      @(posedge clk);
      #1;
      if (s_ov && s_ordy) begin
         if (s_ol) last_step = stepno;
         nout++;
      end
      if ((s_jv & job_ready) != '0) ndisp++;
      for (int k = 0; k < NC; k++) begin
         if (frag_valid[k] && s_fr[k]) pend[k] = 1'b0;
         if (s_jv[k] && job_ready[k]) begin
            pend[k] = 1'b1;
            cdat[k] = {s_jy, s_jx};
            cnt[k]  = dly[k];
         end else if (pend[k] && cnt[k] > 0) begin
            cnt[k]--;
         end
      end
      drive_frags();
      if (!held && nout == hold_at) begin
         out_ready = 1'b0;
         hold_cnt  = 20;
         held      = 1'b1;
      end else if (hold_cnt > 0) begin
         hold_cnt--;
         if (hold_cnt == 0) out_ready = 1'b1;
      end
   endtask

   task automatic start_frame(input int w, input int h);
      fw = w; fh = h; ntot = w * h;
      nout = 0; ndisp = 0; done_step = -1; last_step = -1;
      busy_cyc = 0; stall2 = 0; stab = 0;
      frame_done = 1'b0; held = 1'b0; hold_cnt = 0;
      image_width  = 16'(w);
      image_height = 16'(h);
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic finish_frame();
      int guard = 0;
      while (!frame_done && guard < 500) begin
         step();
         guard++;
      end
      chk("frame_timeout", 32'(frame_done), 32'd1);
      chk("frag_count", 32'(nout), 32'(ntot));
      chk("job_count", 32'(ndisp), 32'(ntot));
      chk("done_after_last", 32'(done_step), 32'(last_step + 1));
      chk("busy_at_done", 32'(s_busy), 32'd0);
      chk("perf_cycles", s_perf, perf_exp());
   endtask

   initial begin
      resetn = 1'b0; start = 1'b0; out_ready = 1'b1; job_ready = '1;
      image_width = '0; image_height = '0;
      for (int k = 0; k < NC; k++) dly[k] = 3;
      clear_cores();
      stepno = 0; hold_at = -1; ntot = 0; nout = 0; ndisp = 0; fw = 0;
      p_ov = 1'b0; p_ordy = 1'b1; p_od = '0; p_ol = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_job_valid", 32'(job_valid), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_perf", perf_cycles, 32'd0);
      resetn = 1'b1;
      step();

      // 4x2 frame, uniform 3-cycle cores
      start_frame(4, 2);
      finish_frame();
      step();

      // 3x3 frame, core 1 late: order preserved, core 2 stalls
      dly[0] = 1; dly[1] = 10; dly[2] = 1; dly[3] = 1;
      start_frame(3, 3);
      finish_frame();
      chk("core2_stalled", 32'(stall2 > 0), 32'd1);

      // 4x4 frame with a 20-cycle out_ready stall after the third fragment
      for (int k = 0; k < NC; k++) dly[k] = 1;
      hold_at = 3;
      start_frame(4, 4);
      finish_frame();
      chk("hold_observed", 32'(stab >= 15), 32'd1);
      hold_at = -1;

      // empty frame
      start_frame(0, 5);
      chk("zero_busy_at_start", 32'(s_busy), 32'd0);
      step();
      chk("zero_done", 32'(s_done), 32'd1);
      chk("zero_busy", 32'(s_busy), 32'd0);
      chk("zero_jobs", 32'(s_jv), 32'd0);
      step();
      chk("zero_done_pulse", 32'(s_done), 32'd0);

      // reset in the middle of an 8x8 frame
      dly[0] = 2; dly[1] = 2; dly[2] = 2; dly[3] = 2;
      start_frame(8, 8);
      repeat (10) step();
      chk("mid_busy", 32'(s_busy), 32'd1);
      resetn = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      chk("arst_job_valid", 32'(job_valid), 32'd0);
      chk("arst_frag_ready", 32'(frag_ready), 32'd0);
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_out_last", 32'(out_last), 32'd0);
      chk("arst_job_xy", {job_y, job_x}, 32'd0);
      chk("arst_perf", perf_cycles, 32'd0);
      clear_cores();
      p_ov = 1'b0;
      @(posedge clk);
      #1;
      resetn = 1'b1;
      start_frame(2, 1);
      finish_frame();

      // 2x2 frame: perf counter matches busy cycles and holds after done
      start_frame(2, 2);
      finish_frame();
      step();
      chk("perf_hold", s_perf, perf_exp());

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/render_sched.md
RENDER_SCHED -- requirements
Module: render_sched

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, number of render datapaths served (2..8).
REQ-002 SHALL have parameter COORD_W, default 16, pixel coordinate width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle frame start request.
REQ-006 SHALL have port image_width  input  COORD_W  frame width in pixels, sampled on accepted start.
REQ-007 SHALL have port image_height  input  COORD_W  frame height in pixels, sampled on accepted start.
REQ-008 SHALL have port busy  output  1  high from accepted start until done.
REQ-009 SHALL have port done  output  1  one-cycle pulse at frame completion.
REQ-010 SHALL have port job_valid  output  NUM_CORES  per-core pixel job offer.
REQ-011 SHALL have port job_ready  input  NUM_CORES  per-core job acceptance.
REQ-012 SHALL have port job_x, job_y  output  COORD_W each  coordinates of the offered job (shared by all cores).
REQ-013 SHALL have port frag_valid  input  NUM_CORES  per-core result available.
REQ-014 SHALL have port frag_data  input  32*NUM_CORES  per-core result, core k at bits [32k+31:32k].
REQ-015 SHALL have port frag_ready  output  NUM_CORES  per-core result consumed.
REQ-016 SHALL have port out_valid/out_ready/out_data[31:0]/out_last  out/in/out/out  merged raster-order fragment stream.
REQ-017 SHALL have port perf_cycles  output  32  frame cycle count (see Configuration).

Function
REQ-018 SHALL implement states IDLE, RUN, DRAIN; start accepted only in IDLE, ignored otherwise.
REQ-019 On accepted start with width or height zero: done pulses next cycle, busy stays low, state stays IDLE.
REQ-020 On accepted start with nonzero dims: latch dims, x=y=0, dispatch pointer dptr=0, collect pointer cptr=0, enter RUN next cycle.
REQ-021 Each core SHALL hold at most one outstanding job, tracked by flag outstanding[k].
REQ-022 In RUN, job_valid[dptr]=1 iff outstanding[dptr]==0; all other job_valid bits 0; job_x/job_y = current x/y.
REQ-023 On job_valid[dptr]&job_ready[dptr]: set outstanding[dptr]; dptr=(dptr+1) mod NUM_CORES; x increments, wrapping to 0 with y+1 at x==width-1.
REQ-024 Dispatch of pixel (width-1,height-1) SHALL move state to DRAIN; no further jobs offered.
REQ-025 Collection in RUN and DRAIN: out_valid = frag_valid[cptr]&outstanding[cptr]; out_data = frag_data[cptr]; frag_ready[cptr]=out_ready&outstanding[cptr]; other frag_ready bits 0; zero-cycle combinational path.
REQ-026 On out_valid&out_ready: clear outstanding[cptr], cptr=(cptr+1) mod NUM_CORES, increment 32-bit collected count.
REQ-027 Output order SHALL equal raster dispatch order regardless of core completion order.
REQ-028 out_last SHALL be high with out_valid on the width*height-th fragment only (32-bit product).
REQ-029 Handshake of the last fragment: next cycle state IDLE, busy low, done pulses one cycle.
REQ-030 Dispatch and collection on the same cycle (different or same core) SHALL both take effect; a core cleared this cycle is eligible for dispatch next cycle.
REQ-031 out_valid once asserted SHALL hold with stable out_data/out_last until out_ready.
REQ-032 In IDLE: job_valid, frag_ready, out_valid all 0.

Reset
REQ-033 resetn low SHALL asynchronously force state IDLE, busy=0, done=0, outstanding=0, dptr=cptr=0, x=y=0, count=0, perf_cycles=0.
REQ-034 Reset mid-frame SHALL abandon the frame without done; core results pending at reset are not consumed.

Configuration
REQ-035 Macro RENDER_SCHED_PERF_EN defined: perf_cycles clears on accepted start, increments each busy cycle, holds after done until next start.
REQ-036 Macro undefined: perf_cycles is constant 0 and the counter is not synthesised.

Verification
REQ-037 4x2 frame, NUM_CORES=4, cores return after 3 cycles, out_ready=1 -> 8 fragments in raster order, out_last on 8th, done one cycle later.
REQ-038 3x3 frame, core 1 replies 10 cycles late, others 1 cycle -> output order unchanged, core 2 result stalls until core 1 consumed.
REQ-039 out_ready low 20 cycles mid-frame -> out_valid/out_data stable, no job to a core with outstanding set.
REQ-040 start with width=0, height=5 -> done pulse next cycle, busy never high, no job_valid.
REQ-041 resetn low during RUN of 8x8 frame -> all outputs zero immediately; new 2x1 frame completes correctly afterward.
REQ-042 RENDER_SCHED_PERF_EN defined, 2x2 frame -> perf_cycles equals busy-high cycle count; undefined -> perf_cycles=0.
